// File: rtl/pedestal_pkg.sv
// Shared types and helpers for the windowed pedestal averager.
// PEDESTAL_SUB_EN selects the optional baseline-subtracted output path.
package pedestal_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        UPDATE
    } state_e;

    function automatic int acc_w(input int dw, input int log2n);
        return dw + log2n;
    endfunction

    function automatic longint sat_max(input int dw);
        return (longint'(1) <<< (dw - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int dw);
        return -(longint'(1) <<< (dw - 1));
    endfunction

endpackage

// File: rtl/pedestal_sat_sub.sv
// Registered saturating signed subtractor: y = sat(a - b), one cycle latency.
// Built only when PEDESTAL_SUB_EN is defined.
`ifdef PEDESTAL_SUB_EN
module pedestal_sat_sub
    import pedestal_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en_i,
    input  logic                 vld_i,
    input  logic signed [DW-1:0] a_i,
    input  logic signed [DW-1:0] b_i,
    output logic signed [DW-1:0] y_o,
    output logic                 y_valid_o
);

    localparam logic signed [DW-1:0] MAXV = DW'(sat_max(DW));
    localparam logic signed [DW-1:0] MINV = DW'(sat_min(DW));

    logic signed [DW:0]   diff;
    logic signed [DW-1:0] sat_d;
    logic signed [DW-1:0] y_q;
    logic                 vld_q;

    // One guard bit: overflow shows as disagreement of the top two bits.
    always_comb begin
        diff  = {a_i[DW-1], a_i} - {b_i[DW-1], b_i};
        sat_d = diff[DW-1:0];
        if (diff[DW] != diff[DW-1]) begin
            sat_d = diff[DW] ? MINV : MAXV;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !en_i) begin
            y_q   <= '0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= vld_i;
            if (vld_i) begin
                y_q <= sat_d;
            end
        end
    end

    assign y_o       = y_q;
    assign y_valid_o = vld_q;

endmodule
`endif

// File: rtl/pedestal_window_avg.sv
// Windowed pedestal averager with veto, holdoff and rounded mean publish.
// Define PEDESTAL_SUB_EN to build the saturating baseline subtractor on y.
module pedestal_window_avg
    import pedestal_pkg::*;
#(
    parameter int DW         = 16,
    parameter int LOG2_N     = 8,
    parameter int HOLDOFF    = 64,
    parameter bit ABORT_VETO = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic signed [DW-1:0] x,
    input  logic                 x_valid,
    input  logic                 veto,
    output logic signed [DW-1:0] ped,
    output logic                 ped_valid,
    output logic                 ped_upd,
    output logic signed [DW-1:0] y,
    output logic                 y_valid
);

    localparam int ACC_W = acc_w(DW, LOG2_N);
    localparam int HW    = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam logic [LOG2_N-1:0] LAST = '1;
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) <<< (LOG2_N - 1);

    state_e                   state_q, state_d;
    logic signed [ACC_W-1:0]  sum_q, sum_d, full;
    logic [LOG2_N-1:0]        cnt_q, cnt_d;
    logic [HW-1:0]            hold_q, hold_d, hold_eff;
    logic signed [DW-1:0]     ped_q, ped_d;
    logic                     pvld_q, pvld_d;
    logic                     veto_q, en_q;
    logic                     rise, fall, accept, last;

    // The falling-edge cycle already counts as the first held-off strobe.
    always_comb begin
        rise     = veto & ~veto_q;
        fall     = ~veto & veto_q;
        hold_eff = fall ? HW'(HOLDOFF) : hold_q;
        accept   = enable && (state_q != IDLE) && x_valid
                   && !veto && (hold_eff == '0);
        last     = accept && (cnt_q == LAST);
        full     = sum_q + {{LOG2_N{x[DW-1]}}, x};

        hold_d = hold_eff;
        if (veto) begin
            hold_d = '0;
        end else if (hold_eff != '0 && x_valid) begin
            hold_d = hold_eff - 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        ped_d   = ped_q;
        pvld_d  = pvld_q;
        if (!enable) begin
            state_d = IDLE;
            sum_d   = '0;
            cnt_d   = '0;
            pvld_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE:    state_d = ACCUM;
                ACCUM:   state_d = last ? UPDATE : ACCUM;
                UPDATE:  state_d = last ? UPDATE : ACCUM;
                default: state_d = IDLE;
            endcase
            if (ABORT_VETO && rise) begin
                sum_d = '0;
                cnt_d = '0;
            end
            // Final sample goes straight into the mean; sum restarts empty.
            if (last) begin
                sum_d  = '0;
                cnt_d  = '0;
                ped_d  = DW'((full + HALF) >>> LOG2_N);
                pvld_d = 1'b1;
            end else if (accept) begin
                sum_d = full;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sum_q   <= '0;
            cnt_q   <= '0;
            hold_q  <= '0;
            ped_q   <= '0;
            pvld_q  <= 1'b0;
            veto_q  <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            ped_q   <= ped_d;
            pvld_q  <= pvld_d;
            veto_q  <= veto;
            en_q    <= enable;
        end
    end

    assign ped       = en_q ? ped_q : '0;
    assign ped_valid = pvld_q;
    assign ped_upd   = (state_q == UPDATE);

`ifdef PEDESTAL_SUB_EN
    pedestal_sat_sub #(
        .DW(DW)
    ) u_sub (
        .clk      (clk),
        .reset    (reset),
        .en_i     (enable),
        .vld_i    (x_valid & pvld_q & enable),
        .a_i      (x),
        .b_i      (ped),
        .y_o      (y),
        .y_valid_o(y_valid)
    );
`else
    assign y       = '0;
    assign y_valid = 1'b0;
`endif

endmodule
